// File: rtl/ad1860_pkg.sv
// Shared types and word conversion for the AD1860 load scheduler.
// round_sat turns one IN_BITS PCM sample into a WORD-bit DAC word.
package ad1860_pkg;

  localparam int IN_BITS = 24;
  localparam int WORD    = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam logic [IN_BITS:0] RND_HALF = (IN_BITS+1)'(1) << (IN_BITS - WORD - 1);
  localparam logic [WORD-1:0]  WORD_MAX = {1'b0, {(WORD-1){1'b1}}};
  localparam logic [WORD-1:0]  WORD_MIN = {1'b1, {(WORD-1){1'b0}}};

  // Rounding can only overflow upward, seen as a sign change in the extended sum.
  function automatic logic [WORD-1:0] round_sat(input logic [IN_BITS-1:0] in,
                                                input logic inv,
                                                input logic mute);
    logic [IN_BITS:0] sum;
    logic [WORD-1:0]  w;
    sum = {in[IN_BITS-1], in} + RND_HALF;
    if (sum[IN_BITS] != sum[IN_BITS-1]) w = WORD_MAX;
    else                                w = sum[IN_BITS-1 -: WORD];
    if (inv) w = (w == WORD_MIN) ? WORD_MAX : -w;
    if (mute) w = '0;
    return w;
  endfunction

endpackage

// File: rtl/dac_word_serializer.sv
// One DAC lane: WORD-bit MSB-first shift register clocked out on a divided bit clock.
// bck is low for the first half of every bit and sdo changes only at bit start.
module dac_word_serializer #(
  parameter int WORD    = 18,
  parameter int BCK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [WORD-1:0] word,
  input  logic            start,
  output logic            done,
  output logic            bck,
  output logic            sdo
);

  localparam int DW = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam int BW = $clog2(WORD);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD - 1);

  logic [WORD-1:0] sreg;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            active;
  logic            bit_end;

  assign bit_end = active && (div_cnt == DIV_LAST);
  assign done    = bit_end && (bit_cnt == BIT_LAST);
  assign sdo     = active & sreg[WORD-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      bck     <= 1'b0;
      active  <= 1'b0;
    end else if (load) begin
      sreg    <= word;
      div_cnt <= '0;
      bit_cnt <= '0;
      bck     <= 1'b0;
      active  <= start;
    end else if (active) begin
      if (bit_end) begin
        div_cnt <= '0;
        bck     <= 1'b0;
        sreg    <= sreg << 1;
        if (done) active  <= 1'b0;
        else      bit_cnt <= bit_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        bck     <= (DW'(div_cnt + 1'b1) >= DIV_HALF);
      end
    end
  end

endmodule

// File: rtl/ad1860_load_scheduler.sv
// Buffers one stereo pair and, on each frame strobe, loads NDAC AD1860-style DACs
// in parallel: convert words, shift them out together, then pulse latch enable.
module ad1860_load_scheduler
  import ad1860_pkg::*;
#(
  parameter int NDAC    = 4,
  parameter int BCK_DIV = 4,
  parameter int LE_HOLD = 2
) (
  input  logic               mck_i,
  input  logic               rst_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [IN_BITS-1:0] s_left_i,
  input  logic [IN_BITS-1:0] s_right_i,
  input  logic               frame_i,
  input  logic [NDAC-1:0]    cfg_src_i,
  input  logic [NDAC-1:0]    cfg_inv_i,
  input  logic               cfg_mute_i,
  output logic               dac_bck_o,
  output logic [NDAC-1:0]    dac_sdo_o,
  output logic [NDAC-1:0]    dac_le_o,
  output logic               busy_o,
  output logic               underrun_o,
  output logic               late_o,
  output logic [1:0]         dbg_state_o,
  output logic               dbg_lane_sync_o
);

  localparam int LW = (LE_HOLD > 1) ? $clog2(LE_HOLD) : 1;
  localparam logic [LW-1:0] LE_LAST = LW'(LE_HOLD - 1);

  state_t state, state_nxt;
  logic [LW-1:0]      le_cnt;
  logic               le_last;
  logic               hold_vld;
  logic [IN_BITS-1:0] hold_l, hold_r, last_l, last_r;
  logic               accept, frame_idle, load;
  logic [WORD-1:0]    lane_word [NDAC];
  logic [NDAC-1:0]    lane_done, lane_bck;

  // Handshake: a pair transfers on any cycle with s_valid_i & s_ready_o; ready is
  // simply "holding register empty" and does not depend on s_valid_i.
  assign s_ready_o  = ~hold_vld;
  assign accept     = s_valid_i & s_ready_o;
  assign frame_idle = frame_i && (state == ST_IDLE);
  assign load       = (state == ST_LOAD);
  assign le_last    = (le_cnt == LE_LAST);

  always_ff @(posedge mck_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      le_cnt <= '0;
    end else begin
      state  <= state_nxt;
      le_cnt <= (state == ST_LATCH && !le_last) ? le_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_i) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (lane_done[0]) state_nxt = ST_LATCH;
      ST_LATCH: if (le_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A pair accepted alongside the strobe can only land when the register was empty,
  // so it never collides with the consume path and waits for the next frame.
  always_ff @(posedge mck_i) begin
    if (rst_i) begin
      hold_vld   <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      last_l     <= '0;
      last_r     <= '0;
      underrun_o <= 1'b0;
      late_o     <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      late_o     <= frame_i && (state != ST_IDLE);
      if (frame_idle) begin
        if (hold_vld) begin
          last_l   <= hold_l;
          last_r   <= hold_r;
          hold_vld <= 1'b0;
        end else begin
          underrun_o <= 1'b1;
        end
      end
      if (accept) begin
        hold_vld <= 1'b1;
        hold_l   <= s_left_i;
        hold_r   <= s_right_i;
      end
    end
  end

  for (genvar i = 0; i < NDAC; i++) begin : g_lane
    logic [IN_BITS-1:0] sel;
    assign sel          = cfg_src_i[i] ? last_r : last_l;
    assign lane_word[i] = round_sat(sel, cfg_inv_i[i], cfg_mute_i);

    dac_word_serializer #(
      .WORD    (WORD),
      .BCK_DIV (BCK_DIV)
    ) u_ser (
      .clk   (mck_i),
      .rst   (rst_i),
      .load  (load),
      .word  (lane_word[i]),
      .start (load),
      .done  (lane_done[i]),
      .bck   (lane_bck[i]),
      .sdo   (dac_sdo_o[i])
    );
  end

  assign dac_bck_o       = lane_bck[0];
  assign dac_le_o        = {NDAC{state == ST_LATCH}};
  assign busy_o          = (state != ST_IDLE);
  assign dbg_state_o     = state;
  assign dbg_lane_sync_o = (lane_bck == {NDAC{lane_bck[0]}}) &&
                           (lane_done == {NDAC{lane_done[0]}});

endmodule

// File: tb/tb_ad1860_load_scheduler.sv
// Bench for ad1860_load_scheduler: random pairs/config against a plain-arithmetic
// word model; every DAC frame is captured bit by bit from the pins.
module tb_ad1860_load_scheduler;

  localparam int NDAC      = 4;
  localparam int BCK_DIV   = 4;
  localparam int LE_HOLD   = 2;
  localparam int WORD      = 18;
  localparam int IN_BITS   = 24;
  localparam int SHIFT_CYC = WORD * BCK_DIV;
  localparam int FRAME_END = 1 + SHIFT_CYC + LE_HOLD;
  localparam int WMAX      = (1 << (WORD - 1)) - 1;
  localparam int RSHIFT    = IN_BITS - WORD;

  logic               mck = 1'b0;
  logic               rst_i = 1'b1;
  logic               s_valid_i = 1'b0;
  logic               s_ready_o;
  logic [IN_BITS-1:0] s_left_i = '0;
  logic [IN_BITS-1:0] s_right_i = '0;
  logic               frame_i = 1'b0;
  logic [NDAC-1:0]    cfg_src_i = '0;
  logic [NDAC-1:0]    cfg_inv_i = '0;
  logic               cfg_mute_i = 1'b0;
  logic               dac_bck_o;
  logic [NDAC-1:0]    dac_sdo_o;
  logic [NDAC-1:0]    dac_le_o;
  logic               busy_o;
  logic               underrun_o;
  logic               late_o;
  logic [1:0]         dbg_state_o;
  logic               dbg_lane_sync_o;

  ad1860_load_scheduler #(.NDAC(NDAC), .BCK_DIV(BCK_DIV), .LE_HOLD(LE_HOLD)) dut (
    .mck_i           (mck),
    .rst_i           (rst_i),
    .s_valid_i       (s_valid_i),
    .s_ready_o       (s_ready_o),
    .s_left_i        (s_left_i),
    .s_right_i       (s_right_i),
    .frame_i         (frame_i),
    .cfg_src_i       (cfg_src_i),
    .cfg_inv_i       (cfg_inv_i),
    .cfg_mute_i      (cfg_mute_i),
    .dac_bck_o       (dac_bck_o),
    .dac_sdo_o       (dac_sdo_o),
    .dac_le_o        (dac_le_o),
    .busy_o          (busy_o),
    .underrun_o      (underrun_o),
    .late_o          (late_o),
    .dbg_state_o     (dbg_state_o),
    .dbg_lane_sync_o (dbg_lane_sync_o)
  );

  // clock / watchdog
  always #5 mck = ~mck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: holding register, last pair, word arithmetic
  bit                 m_hold_vld;
  logic [IN_BITS-1:0] m_hold_l, m_hold_r, m_last_l, m_last_r;

  function automatic logic [31:0] ref_word(input logic [IN_BITS-1:0] x, input bit inv, input bit mute);
    int v;
    int r;
    v = int'($signed(x));
    r = (v + (1 << (RSHIFT - 1))) >>> RSHIFT;
    if (r > WMAX) r = WMAX;
    if (inv) begin
      r = -r;
      if (r > WMAX) r = WMAX;
    end
    if (mute) r = 0;
    return 32'(r) & ((32'd1 << WORD) - 1);
  endfunction

  function automatic logic [IN_BITS-1:0] pick_sample();
    case ($urandom_range(0, 5))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      2:       return 24'h7FFFE0;
      3:       return 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  // driver tasks
  task automatic reset_dut();
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    frame_i = 1'b0;
    repeat (3) @(posedge mck);
    #1 rst_i = 1'b0;
    m_hold_vld = 0;
    m_hold_l = '0; m_hold_r = '0; m_last_l = '0; m_last_r = '0;
    @(negedge mck);
    check_val("rst_outputs",
              {31'd0, s_ready_o, busy_o, dac_bck_o, dac_sdo_o, dac_le_o, underrun_o, late_o},
              {31'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0});
  endtask

  task automatic send_pair(input logic [IN_BITS-1:0] l, input logic [IN_BITS-1:0] r);
    @(posedge mck); #1;
    s_valid_i = 1'b1; s_left_i = l; s_right_i = r;
    @(negedge mck);
    check_val("ready_empty", 32'(s_ready_o), 32'd1);
    @(posedge mck); #1;
    s_valid_i = 1'b0;
    m_hold_vld = 1; m_hold_l = l; m_hold_r = r;
    @(negedge mck);
    check_val("ready_held", 32'(s_ready_o), 32'd0);
  endtask

  // Frame strobe in cycle 0; cycle c is the c-th cycle after the strobe.
  task automatic run_frame(input logic [NDAC-1:0] src, input logic [NDAC-1:0] inv, input bit mute,
                           input int late_at, input int rst_at, input bit accept_same,
                           input logic [IN_BITS-1:0] al, input logic [IN_BITS-1:0] ar);
    bit              exp_ur;
    bit              aborted;
    int              shape_bad, le_cnt, le_first, late_cnt, b, ph;
    logic [WORD-1:0] cap [NDAC];
    exp_ur = !m_hold_vld;
    if (m_hold_vld) begin
      m_last_l = m_hold_l; m_last_r = m_hold_r; m_hold_vld = 0;
    end
    if (rst_at < 0)
      for (int l = 0; l < NDAC; l++)
        exp_q.push_back(ref_word(src[l] ? m_last_r : m_last_l, inv[l], mute));
    if (accept_same) begin
      m_hold_vld = 1; m_hold_l = al; m_hold_r = ar;
    end
    aborted = 0; shape_bad = 0; le_cnt = 0; le_first = -1; late_cnt = 0;
    for (int l = 0; l < NDAC; l++) cap[l] = '0;

    @(posedge mck); #1;
    frame_i = 1'b1;
    cfg_src_i = src; cfg_inv_i = inv; cfg_mute_i = mute;
    if (accept_same) begin
      s_valid_i = 1'b1; s_left_i = al; s_right_i = ar;
    end
    for (int c = 1; c <= FRAME_END + 2; c++) begin
      @(posedge mck); #1;
      frame_i = (c == late_at);
      s_valid_i = 1'b0;
      rst_i = (c == rst_at);
      if (c == 2) begin
        cfg_src_i = ~src; cfg_inv_i = ~inv; cfg_mute_i = ~mute;
      end
      @(negedge mck);
      if (c == 1) check_val("busy_underrun", {30'd0, busy_o, underrun_o}, {30'd0, 1'b1, exp_ur});
      if (c == 2) check_val("underrun_width", 32'(underrun_o), 32'd0);
      if (rst_at >= 0 && c > rst_at) aborted = 1;
      if (late_o) late_cnt++;
      if (c >= 2 && c <= 1 + SHIFT_CYC && !aborted) begin
        b  = (c - 2) / BCK_DIV;
        ph = (c - 2) % BCK_DIV;
        if (dac_bck_o !== (ph >= BCK_DIV / 2)) shape_bad++;
        if (!dbg_lane_sync_o) shape_bad++;
        for (int l = 0; l < NDAC; l++) begin
          if (ph == 0) cap[l][WORD-1-b] = dac_sdo_o[l];
          else if (dac_sdo_o[l] !== cap[l][WORD-1-b]) shape_bad++;
        end
      end
      if (dac_le_o == {NDAC{1'b1}}) begin
        le_cnt++;
        if (le_first < 0) le_first = c;
        if (dac_sdo_o !== '0 || dac_bck_o !== 1'b0) shape_bad++;
      end else if (dac_le_o !== '0) shape_bad++;
      if (late_at > 0 && c == late_at + 1) check_val("late_pulse", 32'(late_o), 32'd1);
      if (rst_at >= 0 && c == rst_at + 1)
        check_val("mid_reset_outputs",
                  {31'd0, s_ready_o, busy_o, dac_bck_o, dac_sdo_o, dac_le_o, underrun_o, late_o},
                  {31'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0});
      if (c == FRAME_END + 1) check_val("busy_end", 32'(busy_o), 32'd0);
    end
    check_val("shape_errors", 32'(shape_bad), 32'd0);
    check_val("late_count", 32'(late_cnt), (late_at > 0 && late_at <= FRAME_END) ? 32'd1 : 32'd0);
    if (rst_at < 0) begin
      check_val("le_cycles", 32'(le_cnt), 32'(LE_HOLD));
      check_val("le_start", 32'(le_first), 32'(2 + SHIFT_CYC));
      for (int l = 0; l < NDAC; l++)
        check_val($sformatf("lane%0d_word", l), 32'(cap[l]), exp_q.pop_front());
    end else begin
      check_val("le_after_reset", 32'(le_cnt), 32'd0);
      m_hold_vld = 0;
      m_hold_l = '0; m_hold_r = '0; m_last_l = '0; m_last_r = '0;
    end
  endtask

  // main sequence
  initial begin
    logic [NDAC-1:0] r_src, r_inv;
    bit              r_mute;
    int              r_late;

    reset_dut();
    check_val("rst_state", 32'(dbg_state_o), 32'd0);

    // empty register after reset: underrun, zero words
    run_frame(4'b0000, 4'b0000, 0, -1, -1, 0, '0, '0);

    // directed conversion and source mapping
    send_pair(24'h123456, 24'hFEDCBA);
    run_frame(4'b1010, 4'b0000, 0, -1, -1, 0, '0, '0);

    // positive saturation, and negation of the most negative word
    send_pair(24'h7FFFF0, 24'h800000);
    run_frame(4'b1010, 4'b1010, 0, -1, -1, 0, '0, '0);

    // mute overrides inversion
    send_pair(24'h2468AC, 24'hABCDEF);
    run_frame(4'b0110, 4'b1111, 1, -1, -1, 0, '0, '0);

    // late strobe 30 cycles into SHIFT, then a normal frame
    send_pair(24'h3C3C3C, 24'hC3C3C3);
    run_frame(4'b1100, 4'b0001, 0, 2 + 30, -1, 0, '0, '0);
    send_pair(24'h0F0F0F, 24'hF0F0F0);
    run_frame(4'b0011, 4'b0000, 0, -1, -1, 0, '0, '0);

    // no new pair: underrun repeats the previous words
    run_frame(4'b0011, 4'b0000, 0, -1, -1, 0, '0, '0);

    // pair arriving with the strobe on an empty register waits for the next frame
    run_frame(4'b1001, 4'b0000, 0, -1, -1, 1, 24'h555555, 24'hAAAAAA);
    check_val("ready_after_same", 32'(s_ready_o), 32'd0);
    run_frame(4'b1001, 4'b0100, 0, -1, -1, 0, '0, '0);

    // reset mid-SHIFT: no latch, last pair cleared
    send_pair(24'h654321, 24'h9ABCDE);
    run_frame(4'b0101, 4'b0000, 0, -1, 40, 0, '0, '0);
    run_frame(4'b0101, 4'b0000, 0, -1, -1, 0, '0, '0);

    // randomized frames
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) != 0 && !m_hold_vld) send_pair(pick_sample(), pick_sample());
      r_src  = 4'($urandom);
      r_inv  = 4'($urandom);
      r_mute = ($urandom_range(0, 4) == 0);
      r_late = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, FRAME_END)) : -1;
      run_frame(r_src, r_inv, r_mute, r_late, -1, 0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
